// File: rtl/jpeg_idct_xpose_buf.sv
// Multi-bank 8x8 transpose buffer between the IDCT row and column passes.
// Define JPEG_IDCT_XPOSE_SAT_EN to saturate output lanes instead of truncating.
module jpeg_idct_xpose_buf #(
  parameter int NUM_BANKS = 2,
  parameter int LANES     = 4,
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 32,
  parameter int IDX_W     = $clog2(64 / LANES)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         img_start_i,
  input  logic                         inport_valid_i,
  input  logic [IN_WIDTH-1:0]          inport_data_i,
  input  logic [5:0]                   inport_idx_i,
  output logic                         ready_o,
  output logic                         v_o,
  output logic [LANES*OUT_WIDTH-1:0]   outport_data_o,
  output logic [IDX_W-1:0]             outport_idx_o,
  input  logic                         yumi_i
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int BEATS  = 64 / LANES;

  logic [IN_WIDTH-1:0]  mem [NUM_BANKS][64];
  logic [NUM_BANKS-1:0] full;
  logic [BANK_W-1:0]    wr_bank;
  logic [BANK_W-1:0]    rd_bank;
  logic [6:0]           wr_cnt;
  logic [IDX_W-1:0]     k;
  logic                 flush;
  logic                 wr_fire;
  logic                 rd_fire;
  logic                 wr_last;
  logic                 rd_last;

  assign flush         = rst_i || img_start_i;
  assign ready_o       = !full[wr_bank];
  assign v_o           = full[rd_bank];
  assign wr_fire       = inport_valid_i && ready_o;
  assign rd_fire       = v_o && yumi_i;
  assign wr_last       = wr_cnt == 7'd63;
  assign rd_last       = k == IDX_W'(BEATS - 1);
  assign outport_idx_o = k;

  function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] b);
    return (b == BANK_W'(NUM_BANKS - 1)) ? '0 : b + BANK_W'(1);
  endfunction

  function automatic logic [OUT_WIDTH-1:0] shape(input logic [IN_WIDTH-1:0] s);
`ifdef JPEG_IDCT_XPOSE_SAT_EN
    logic [IN_WIDTH-OUT_WIDTH:0] top;
    top = s[IN_WIDTH-1:OUT_WIDTH-1];
    // the sample fits when every bit above the output sign bit copies it
    if ((&top) || !(|top)) return s[OUT_WIDTH-1:0];
    return s[IN_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
`else
    return s[OUT_WIDTH-1:0];
`endif
  endfunction

  always_ff @(posedge clk_i) begin
    if (flush) begin
      full    <= '0;
      wr_bank <= '0;
      rd_bank <= '0;
      wr_cnt  <= '0;
      k       <= '0;
    end else begin
      if (wr_fire) begin
        if (wr_last) begin
          full[wr_bank] <= 1'b1;
          wr_cnt        <= '0;
          wr_bank       <= next_bank(wr_bank);
        end else begin
          wr_cnt <= wr_cnt + 7'd1;
        end
      end
      if (rd_fire) begin
        if (rd_last) begin
          full[rd_bank] <= 1'b0;
          k             <= '0;
          rd_bank       <= next_bank(rd_bank);
        end else begin
          k <= k + IDX_W'(1);
        end
      end
    end
  end

  // storage is never cleared; a transfer coinciding with a flush is dropped
  always_ff @(posedge clk_i) begin
    if (wr_fire && !flush) mem[wr_bank][inport_idx_i] <= inport_data_i;
  end

  always_comb begin
    outport_data_o = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      logic [5:0] t;
      logic [5:0] addr;
      t    = 6'(k * LANES + l);
      addr = {t[2:0], t[5:3]};
      if (v_o) outport_data_o[l*OUT_WIDTH +: OUT_WIDTH] = shape(mem[rd_bank][addr]);
    end
  end

endmodule

// File: tb/tb_jpeg_idct_xpose_buf.sv
// Bench for jpeg_idct_xpose_buf: four configurations checked every cycle against a
// block-queue model, plus directed transpose, backpressure, flush, reset and width cases.
module tb_jpeg_idct_xpose_buf;

  localparam int NI = 4;

  function automatic int nb_of(input int g);
    case (g)
      0: return 2;
      1: return 3;
      2: return 4;
      default: return 2;
    endcase
  endfunction

  function automatic int ln_of(input int g);
    case (g)
      0: return 4;
      1: return 1;
      2: return 2;
      default: return 8;
    endcase
  endfunction

  function automatic int ow_of(input int g);
    return (g == 0) ? 32 : 9;
  endfunction

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  logic        rst   [NI];
  logic        start [NI];
  logic        vld   [NI];
  logic        yumi  [NI];
  logic [31:0] dat   [NI];
  logic [5:0]  idx   [NI];
  logic        rdy   [NI];
  logic        vo    [NI];
  logic [255:0] od   [NI];
  logic [5:0]  oi    [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int NB = nb_of(g);
    localparam int LN = ln_of(g);
    localparam int OW = ow_of(g);
    logic [LN*OW-1:0]          d;
    logic [$clog2(64/LN)-1:0]  k;
    jpeg_idct_xpose_buf #(
      .NUM_BANKS(NB),
      .LANES(LN),
      .IN_WIDTH(32),
      .OUT_WIDTH(OW)
    ) u_dut (
      .clk_i(clk),
      .rst_i(rst[g]),
      .img_start_i(start[g]),
      .inport_valid_i(vld[g]),
      .inport_data_i(dat[g]),
      .inport_idx_i(idx[g]),
      .ready_o(rdy[g]),
      .v_o(vo[g]),
      .outport_data_o(d),
      .outport_idx_o(k),
      .yumi_i(yumi[g])
    );
    assign od[g] = 256'(d);
    assign oi[g] = 6'(k);
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int i, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, i, got, exp);
    end
  endtask

  // Model: each bank's contents, plus one ring of samples already in output order.
  int mem_m [NI][4][64];
  int ob    [NI][256];
  int head  [NI];
  int cnt   [NI];
  int wcnt  [NI];
  int wb    [NI];
  int done_blk [NI];
  int maxk  [NI];

  function automatic bit m_ready(input int i);
    return ((cnt[i] + 63) / 64) < nb_of(i);
  endfunction

  function automatic bit m_v(input int i);
    return cnt[i] > 0;
  endfunction

  function automatic int m_k(input int i);
    return ((64 - cnt[i] % 64) % 64) / ln_of(i);
  endfunction

  function automatic longint conv(input int i, input int x);
    longint xv, m, r;
    int ow;
    ow = ow_of(i);
    xv = longint'(x);
    if (ow >= 32) return xv;
    m = longint'(1) << ow;
`ifdef JPEG_IDCT_XPOSE_SAT_EN
    if (xv > m / 2 - 1) return m / 2 - 1;
    if (xv < -(m / 2)) return -(m / 2);
    return xv;
`else
    r = xv % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
`endif
  endfunction

  function automatic longint m_lane(input int i, input int l);
    return conv(i, ob[i][(head[i] + l) % 256]);
  endfunction

  function automatic longint dut_lane(input int i, input int l);
    logic [255:0] w;
    longint v, m;
    int ow;
    ow = ow_of(i);
    w  = od[i] >> (l * ow);
    m  = longint'(1) << ow;
    v  = longint'(w[31:0]) & (m - 1);
    if (v >= m / 2) v -= m;
    return v;
  endfunction

  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      if (rst[i] || start[i]) begin
        head[i] = 0;
        cnt[i]  = 0;
        wcnt[i] = 0;
        wb[i]   = 0;
      end else begin
        bit acc;
        acc = vld[i] && m_ready(i);
        if (yumi[i] && m_v(i)) begin
          head[i] = (head[i] + ln_of(i)) % 256;
          cnt[i]  = cnt[i] - ln_of(i);
        end
        if (acc) begin
          mem_m[i][wb[i]][idx[i]] = int'(dat[i]);
          wcnt[i]++;
          if (wcnt[i] == 64) begin
            for (int t = 0; t < 64; t++) begin
              ob[i][(head[i] + cnt[i]) % 256] = mem_m[i][wb[i]][(t % 8) * 8 + t / 8];
              cnt[i]++;
            end
            wcnt[i] = 0;
            wb[i]   = (wb[i] + 1) % nb_of(i);
            done_blk[i]++;
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("ready", i, longint'(rdy[i]), longint'(m_ready(i)));
      chk("valid", i, longint'(vo[i]), longint'(m_v(i)));
      chk("beat_idx", i, longint'(oi[i]), longint'(m_k(i)));
      for (int l = 0; l < ln_of(i); l++)
        chk("lane", i, dut_lane(i, l), m_v(i) ? m_lane(i, l) : 0);
      if (vo[i] && int'(oi[i]) > maxk[i]) maxk[i] = int'(oi[i]);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic int perm(input int n);
    return (n * 37 + 11) % 64;
  endfunction

  task automatic wr(input int i, input int ix, input int val);
    bit took;
    vld[i] = 1'b1;
    idx[i] = 6'(ix);
    dat[i] = val;
    took   = 1'b0;
    for (int n = 0; n < 40 && !took; n++) begin
      took = m_ready(i);
      cyc();
    end
    if (!took) chk("write_timeout", i, 0, 1);
  endtask

  function automatic int rnd_data(input int i);
    if (ow_of(i) == 32 || $urandom_range(3) == 0) return int'($urandom);
    return int'($urandom_range(1200)) - 600;
  endfunction

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; vld[i] = 1'b0; yumi[i] = 1'b0;
      idx[i] = '0;   dat[i] = '0;     maxk[i] = 0;
    end
    cyc(); cyc();
    for (int i = 0; i < NI; i++) rst[i] = 1'b0;
    cyc();
    chk("rst_ready", 0, longint'(rdy[0]), 1);
    chk("rst_valid", 0, longint'(vo[0]), 0);
    chk("rst_idx", 0, longint'(oi[0]), 0);
    chk("rst_data_zero", 0, longint'(od[0] == '0), 1);

    // transpose of value = idx, written in order
    yumi[0] = 1'b1;
    for (int n = 0; n < 63; n++) wr(0, n, n);
    chk("early_valid", 0, longint'(vo[0]), 0);
    wr(0, 63, 63);
    vld[0] = 1'b0;
    chk("xpose_valid", 0, longint'(vo[0]), 1);
    chk("beat0_idx", 0, longint'(oi[0]), 0);
    chk("beat0_l0", 0, dut_lane(0, 0), 0);
    chk("beat0_l1", 0, dut_lane(0, 1), 8);
    chk("beat0_l2", 0, dut_lane(0, 2), 16);
    chk("beat0_l3", 0, dut_lane(0, 3), 24);
    cyc();
    chk("beat1_idx", 0, longint'(oi[0]), 1);
    chk("beat1_l0", 0, dut_lane(0, 0), 32);
    chk("beat1_l1", 0, dut_lane(0, 1), 40);
    chk("beat1_l2", 0, dut_lane(0, 2), 48);
    chk("beat1_l3", 0, dut_lane(0, 3), 56);
    repeat (16) cyc();
    yumi[0] = 1'b0;

    // backpressure: three blocks into two banks with no consumer
    for (int n = 0; n < 128; n++) begin
      if (n == 127) chk("pre_full_ready", 0, longint'(rdy[0]), 1);
      wr(0, n % 64, 1000 + n);
    end
    chk("bp_ready", 0, longint'(rdy[0]), 0);
    vld[0] = 1'b1; idx[0] = 6'(perm(0)); dat[0] = 2000;
    repeat (3) cyc();
    yumi[0] = 1'b1;
    for (int b = 0; b < 16; b++) begin
      cyc();
      if (b == 14) chk("bp_hold", 0, longint'(rdy[0]), 0);
    end
    yumi[0] = 1'b0;
    chk("bp_release", 0, longint'(rdy[0]), 1);
    for (int n = 0; n < 64; n++) wr(0, perm(n), 2000 + n);
    vld[0] = 1'b0;
    yumi[0] = 1'b1;
    repeat (40) cyc();
    yumi[0] = 1'b0;
    chk("bp_drained", 0, longint'(vo[0]), 0);

    // flush mid-block with the other bank full
    rst[0] = 1'b1; cyc(); rst[0] = 1'b0;
    for (int n = 0; n < 64; n++) wr(0, n, 3000 + n);
    vld[0] = 1'b0; yumi[0] = 1'b1;
    repeat (16) cyc();
    yumi[0] = 1'b0;
    for (int n = 0; n < 64; n++) wr(0, perm(n), 4000 + n);
    for (int n = 0; n < 30; n++) wr(0, n, 4500 + n);
    start[0] = 1'b1; idx[0] = 6'd30; dat[0] = 4530;
    cyc();
    start[0] = 1'b0; vld[0] = 1'b0;
    chk("flush_valid", 0, longint'(vo[0]), 0);
    chk("flush_ready", 0, longint'(rdy[0]), 1);
    for (int n = 0; n < 64; n++) wr(0, n, 5000 + n);
    vld[0] = 1'b0;
    chk("clean_valid", 0, longint'(vo[0]), 1);
    chk("clean_l0", 0, dut_lane(0, 0), 5000);
    chk("clean_l1", 0, dut_lane(0, 1), 5008);
    yumi[0] = 1'b1;
    repeat (16) cyc();
    yumi[0] = 1'b0;

    // reset in the middle of a drain
    for (int n = 0; n < 64; n++) wr(0, n, 6000 + n);
    vld[0] = 1'b0; yumi[0] = 1'b1;
    repeat (5) cyc();
    chk("drain_beat", 0, longint'(oi[0]), 5);
    rst[0] = 1'b1; cyc(); rst[0] = 1'b0; yumi[0] = 1'b0;
    chk("rstd_valid", 0, longint'(vo[0]), 0);
    chk("rstd_idx", 0, longint'(oi[0]), 0);
    chk("rstd_data_zero", 0, longint'(od[0] == '0), 1);
    chk("rstd_ready", 0, longint'(rdy[0]), 1);

    // narrowing to 9 bits
    for (int n = 0; n < 64; n++)
      wr(3, n, (n == 0) ? 300 : (n == 8) ? -300 : (n == 16) ? 255 : (n == 24) ? -256 : n);
    vld[3] = 1'b0;
`ifdef JPEG_IDCT_XPOSE_SAT_EN
    chk("sat_l0", 3, dut_lane(3, 0), 255);
    chk("sat_l1", 3, dut_lane(3, 1), -256);
`else
    chk("wrap_l0", 3, dut_lane(3, 0), -212);
    chk("wrap_l1", 3, dut_lane(3, 1), 212);
`endif
    chk("narrow_l2", 3, dut_lane(3, 2), 255);
    chk("narrow_l3", 3, dut_lane(3, 3), -256);
    yumi[3] = 1'b1;
    repeat (8) cyc();
    yumi[3] = 1'b0;

    // random traffic on every configuration
    for (int c = 0; c < 6000; c++) begin
      for (int i = 0; i < NI; i++) begin
        bit init;
        init     = done_blk[i] >= nb_of(i) + ((i == 3) ? 1 : 0);
        vld[i]   = $urandom_range(9) < 7;
        idx[i]   = init ? 6'($urandom_range(63)) : 6'(perm(wcnt[i]));
        dat[i]   = rnd_data(i);
        yumi[i]  = m_v(i) ? ($urandom_range(99) < ((c < 3000) ? 35 : 80)) : ($urandom_range(24) == 0);
        start[i] = init && ($urandom_range(499) == 0);
        rst[i]   = init && ($urandom_range(1199) == 0);
      end
      cyc();
    end
    for (int i = 0; i < NI; i++) begin
      vld[i] = 1'b0; start[i] = 1'b0; rst[i] = 1'b0; yumi[i] = 1'b1;
    end
    repeat (300) cyc();
    for (int i = 0; i < NI; i++) begin
      chk("final_empty", i, longint'(vo[i]), 0);
      chk("idx_wrap", i, maxk[i], 64 / ln_of(i) - 1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
